param_register_file: RTL

// - Parametrised multi-port register file for the core datapath, generalising the fixed 16x32 / 2-read block.
// - Configurable width, depth and read-port count; optional hard-zero r0; byte-lane writes;

---
 rtl/param_register_file_pkg.sv | 26 ++
 rtl/param_register_file_if.sv | 38 +++
 rtl/param_register_file_read_port.sv | 53 +++++
 rtl/param_register_file.sv | 104 ++++++++++
 4 files changed

// File: rtl/param_register_file_pkg.sv
// rtl/param_register_file_pkg.sv - shared constants, types and helpers for the parametrised register file
package regfile_pkg;

  localparam int BYTE = 8;

  // Widest register the merge helper covers; narrower words are zero-extended into it
  localparam int MAX_DW = 256;

  typedef logic [MAX_DW-1:0]      word_t;
  typedef logic [MAX_DW/BYTE-1:0] be_t;

  function automatic int addr_width(input int n);
    return $clog2(n);
  endfunction

  // Byte lane i takes new_w when be[i] is set, otherwise keeps old_w
  function automatic word_t merge_bytes(input word_t old_w, input word_t new_w, input be_t be);
    word_t r;
    r = old_w;
    for (int i = 0; i < MAX_DW/BYTE; i++) begin
      if (be[i]) r[i*BYTE +: BYTE] = new_w[i*BYTE +: BYTE];
    end
    return r;
  endfunction

endpackage

// File: rtl/param_register_file_if.sv
// rtl/param_register_file_if.sv - decode/writeback bus of the register file
interface param_register_file_if
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_REGS       = 16,
  parameter int NUM_READ_PORTS = 2
);

  localparam int AW = addr_width(NUM_REGS);
  localparam int BW = DATA_WIDTH / BYTE;

  logic                               write_en_n;
  logic [AW-1:0]                      write_addr;
  logic [BW-1:0]                      write_be;
  logic [DATA_WIDTH-1:0]              write_data;
  logic                               reserve_en_n;
  logic [AW-1:0]                      reserve_addr;
  logic [NUM_READ_PORTS-1:0]          read_en_n;
  logic [NUM_READ_PORTS*AW-1:0]       read_addr;
  logic [NUM_READ_PORTS*DATA_WIDTH-1:0] read_data;
  logic [NUM_READ_PORTS-1:0]          read_pending;

  modport master (
    output write_en_n, write_addr, write_be, write_data,
    output reserve_en_n, reserve_addr,
    output read_en_n, read_addr,
    input  read_data, read_pending
  );

  modport slave (
    input  write_en_n, write_addr, write_be, write_data,
    input  reserve_en_n, reserve_addr,
    input  read_en_n, read_addr,
    output read_data, read_pending
  );

endinterface

// File: rtl/param_register_file_read_port.sv
// rtl/param_register_file_read_port.sv - one registered read port with bypass and hard-zero gating
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16,
  parameter int AW         = 4,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           read_en_n,
  input  logic [AW-1:0]                  read_addr,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] regs_flat,
  input  logic [NUM_REGS-1:0]            pending,
  input  logic [NUM_REGS-1:0]            pending_next,
  input  logic                           write_hit,
  input  logic [AW-1:0]                  write_addr,
  input  logic [DATA_WIDTH-1:0]          write_merged,
  output logic [DATA_WIDTH-1:0]          read_data,
  output logic                           read_pending
);

  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_pend;

  // Select stored or forwarded value; r0 is forced to zero when it is hard-wired
  always_comb begin
    sel_data = regs_flat[read_addr*DATA_WIDTH +: DATA_WIDTH];
    sel_pend = pending[read_addr];
    if (BYPASS != 0) begin
      sel_pend = pending_next[read_addr];
      if (write_hit && (write_addr == read_addr)) sel_data = write_merged;
    end
    if ((ZERO_REG != 0) && (read_addr == '0)) begin
      sel_data = '0;
      sel_pend = 1'b0;
    end
  end

  // Output registers: capture on an enabled read, hold otherwise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_data    <= '0;
      read_pending <= 1'b0;
    end else if (!read_en_n) begin
      read_data    <= sel_data;
      read_pending <= sel_pend;
    end
  end

endmodule

// File: rtl/param_register_file.sv
// rtl/param_register_file.sv - parametrised multi-port register file with pending scoreboard
module param_register_file
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_REGS       = 16,
  parameter int NUM_READ_PORTS = 2,
  parameter int ZERO_REG       = 1,
  parameter int BYPASS         = 1
) (
  input logic                  clk,
  input logic                  reset,
  param_register_file_if.slave bus
);

  localparam int AW = addr_width(NUM_REGS);
  localparam int BW = DATA_WIDTH / BYTE;

  if ((DATA_WIDTH % BYTE) != 0 || DATA_WIDTH > MAX_DW) begin : g_bad_width
    $error("param_register_file: DATA_WIDTH must be a multiple of 8 and at most %0d", MAX_DW);
  end
  if (NUM_REGS < 2 || (NUM_REGS & (NUM_REGS - 1)) != 0) begin : g_bad_regs
    $error("param_register_file: NUM_REGS must be a power of 2 and at least 2");
  end
  if (NUM_READ_PORTS < 1 || NUM_READ_PORTS > 4) begin : g_bad_ports
    $error("param_register_file: NUM_READ_PORTS must be in 1..4");
  end

  logic [DATA_WIDTH-1:0]          regs [NUM_REGS];
  logic [NUM_REGS*DATA_WIDTH-1:0] regs_flat;
  logic [NUM_REGS-1:0]            pending;
  logic [NUM_REGS-1:0]            pending_next;
  logic                           write_hit;
  logic [DATA_WIDTH-1:0]          write_merged;

  // A write lands unless it targets the hard-wired zero register
  assign write_hit = !bus.write_en_n && !((ZERO_REG != 0) && (bus.write_addr == '0));

  // Merge the enabled byte lanes of the write into the current register value
  always_comb begin
    write_merged = DATA_WIDTH'(merge_bytes(word_t'(regs[bus.write_addr]),
                                           word_t'(bus.write_data),
                                           be_t'(bus.write_be)));
  end

  // Flatten storage so each read port sees a single mux source
  always_comb begin
    regs_flat = '0;
    for (int i = 0; i < NUM_REGS; i++) regs_flat[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
  end

  // Scoreboard update: write clears, reserve sets afterwards so it wins a same-register collision
  always_comb begin
    pending_next = pending;
    if (!bus.write_en_n) pending_next[bus.write_addr] = 1'b0;
    if (!bus.reserve_en_n) pending_next[bus.reserve_addr] = 1'b1;
    if (ZERO_REG != 0) pending_next[0] = 1'b0;
  end

  // Register storage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (write_hit) begin
      regs[bus.write_addr] <= write_merged;
    end
  end

  // Pending-bit vector
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pending <= '0;
    else       pending <= pending_next;
  end

  for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_rd
    logic [DATA_WIDTH-1:0] port_data;
    logic                  port_pend;

    regfile_read_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_REGS   (NUM_REGS),
      .AW         (AW),
      .ZERO_REG   (ZERO_REG),
      .BYPASS     (BYPASS)
    ) u_port (
      .clk          (clk),
      .reset        (reset),
      .read_en_n    (bus.read_en_n[p]),
      .read_addr    (bus.read_addr[p*AW +: AW]),
      .regs_flat    (regs_flat),
      .pending      (pending),
      .pending_next (pending_next),
      .write_hit    (write_hit),
      .write_addr   (bus.write_addr),
      .write_merged (write_merged),
      .read_data    (port_data),
      .read_pending (port_pend)
    );

    assign bus.read_data[p*DATA_WIDTH +: DATA_WIDTH] = port_data;
    assign bus.read_pending[p] = port_pend;
  end

endmodule
